// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO and a fixed-latency busy
// window, and requests a pipeline stall while a mult/div is in flight.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_rd
);

  typedef enum logic { IDLE, BUSY } state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_t;

  state_t      state;
  op_t         op_e;
  logic [3:0]  count;
  logic [31:0] temp_hi;
  logic [31:0] temp_lo;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] bu_safe;
  logic [31:0] qs_mag;
  logic [31:0] rs_mag;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign op_e = op_t'(op);

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign a_mag   = A[31] ? (~A + 32'd1) : A;
  assign b_mag   = B[31] ? (~B + 32'd1) : B;
  assign b_safe  = (B == '0) ? 32'd1 : b_mag;
  assign bu_safe = (B == '0) ? 32'd1 : B;
  assign qs_mag  = a_mag / b_safe;
  assign rs_mag  = a_mag % b_safe;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (op_e)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (B != '0) begin
          res_lo = (A[31] ^ B[31]) ? (~qs_mag + 32'd1) : qs_mag;
          res_hi = A[31] ? (~rs_mag + 32'd1) : rs_mag;
        end
      end
      OP_DIVU: begin
        if (B != '0) begin
          res_lo = A / bu_safe;
          res_hi = A % bu_safe;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op_e)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                temp_hi <= res_hi;
                temp_lo <= res_lo;
                count   <= op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                busy    <= 1'b1;
                state   <= BUSY;
              end
              OP_MTHI: hi <= A;
              OP_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        BUSY: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            hi    <= temp_hi;
            lo    <= temp_lo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_req = busy | (start & ~op[2]);
  assign mdu_rd    = rd_sel ? hi : lo;

endmodule
